// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU operation arbiter and its round-robin picker.
// Optional build macro used by the top level: ALU_ARB_STATS_EN (op counter + busy output).
package alu_arb_pkg;

    localparam int ALU_DW   = 4;
    localparam int ALU_YW   = 12;
    localparam int ALU_OPW  = 3;
    localparam int ALU_SELW = 2;
    localparam int ALU_CNTW = 4;
    localparam int NREQ     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Settle latency is held in a 4-bit down counter, so values above 15 wrap.
    function automatic logic [ALU_CNTW-1:0] lat_init(input int lat);
        return ALU_CNTW'(lat);
    endfunction

endpackage

// File: rtl/alu_arb_rr.sv
// Two-way round-robin picker: prefers requester rr, falls back to the other one.
// Purely combinational so any shared-resource controller can reuse it.
module alu_arb_rr (
    input  logic [1:0] req,
    input  logic       rr,
    output logic [1:0] gnt_onehot,
    output logic       gnt_id
);

    assign gnt_id = req[rr] ? rr : ~rr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_gnt
            assign gnt_onehot[gi] = (|req) && (gnt_id == 1'(gi));
        end
    endgenerate

endmodule

// File: rtl/alu_op_arbiter.sv
// Shares one 4-bit ALU between two valid/ready requesters: grant, settle, capture Y, respond.
// Build with ALU_ARB_STATS_EN defined to add op_count and busy outputs.
module alu_op_arbiter
    import alu_arb_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int DW      = ALU_DW,
    parameter int YW      = ALU_YW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [2*DW-1:0]            req_a,
    input  logic [2*DW-1:0]            req_b,
    input  logic [2*ALU_OPW-1:0]       req_op,
    input  logic [2*ALU_SELW-1:0]      req_sel,
    output logic [DW-1:0]              alu_a,
    output logic [DW-1:0]              alu_b,
    output logic [ALU_OPW-1:0]         alu_op,
    output logic [ALU_SELW-1:0]        alu_sel,
    input  logic [YW-1:0]              alu_y,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [YW-1:0]              rsp_y
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]                op_count,
    output logic                       busy
`endif
);

    localparam logic [ALU_CNTW-1:0] LAT_INIT = lat_init(ALU_LAT);

    arb_state_t            state_reg, state_next;
    logic [ALU_CNTW-1:0]   cnt_reg, cnt_next;
    logic                  rr_reg, rr_next;
    logic [DW-1:0]         alu_a_reg, alu_a_next;
    logic [DW-1:0]         alu_b_reg, alu_b_next;
    logic [ALU_OPW-1:0]    alu_op_reg, alu_op_next;
    logic [ALU_SELW-1:0]   alu_sel_reg, alu_sel_next;
    logic                  rsp_valid_reg, rsp_valid_next;
    logic                  rsp_id_reg, rsp_id_next;
    logic [YW-1:0]         rsp_y_reg, rsp_y_next;

    logic [1:0]            gnt_onehot;
    logic                  gnt_id;

    logic [DW-1:0]         a_arr   [NREQ];
    logic [DW-1:0]         b_arr   [NREQ];
    logic [ALU_OPW-1:0]    op_arr  [NREQ];
    logic [ALU_SELW-1:0]   sel_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi]   = req_a[gi*DW +: DW];
            assign b_arr[gi]   = req_b[gi*DW +: DW];
            assign op_arr[gi]  = req_op[gi*ALU_OPW +: ALU_OPW];
            assign sel_arr[gi] = req_sel[gi*ALU_SELW +: ALU_SELW];
        end
    endgenerate

    alu_arb_rr u_rr (
        .req        (req_valid),
        .rr         (rr_reg),
        .gnt_onehot (gnt_onehot),
        .gnt_id     (gnt_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rr_reg        <= 1'b0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_op_reg    <= '0;
            alu_sel_reg   <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_y_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rr_reg        <= rr_next;
            alu_a_reg     <= alu_a_next;
            alu_b_reg     <= alu_b_next;
            alu_op_reg    <= alu_op_next;
            alu_sel_reg   <= alu_sel_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_id_reg    <= rsp_id_next;
            rsp_y_reg     <= rsp_y_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        rr_next        = rr_reg;
        alu_a_next     = alu_a_reg;
        alu_b_next     = alu_b_reg;
        alu_op_next    = alu_op_reg;
        alu_sel_next   = alu_sel_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_id_next    = rsp_id_reg;
        rsp_y_next     = rsp_y_reg;
        req_ready      = 2'b00;

        case (state_reg)
            IDLE: begin
                // Gate with rst_n so no accept pulse is seen while reset is held.
                if (rst_n && (|req_valid)) begin
                    req_ready    = gnt_onehot;
                    alu_a_next   = a_arr[gnt_id];
                    alu_b_next   = b_arr[gnt_id];
                    alu_op_next  = op_arr[gnt_id];
                    alu_sel_next = sel_arr[gnt_id];
                    rsp_id_next  = gnt_id;
                    cnt_next     = LAT_INIT;
                    state_next   = WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    rsp_y_next     = alu_y;
                    rsp_valid_next = 1'b1;
                    state_next     = RESP;
                end
            end
            RESP: begin
                // The other requester gets priority next, giving strict alternation under load.
                if (rsp_ready) begin
                    rsp_valid_next = 1'b0;
                    rr_next        = ~rsp_id_reg;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_op    = alu_op_reg;
    assign alu_sel   = alu_sel_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_y     = rsp_y_reg;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] op_count_reg, op_count_next;

    always_comb begin
        op_count_next = op_count_reg;
        if ((state_reg == RESP) && rsp_ready && (op_count_reg != 16'hFFFF)) begin
            op_count_next = op_count_reg + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_reg <= 16'd0;
        end else begin
            op_count_reg <= op_count_next;
        end
    end

    assign op_count = op_count_reg;
    assign busy     = (state_reg != IDLE);
`endif

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Directed bench for alu_op_arbiter: one LAT=1 instance for protocol checks plus LAT=0/15 instances for latency.
// Define ALU_ARB_STATS_EN to also check op_count and busy.
module tb_alu_op_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_a, req_b;
    logic [5:0]  req_op;
    logic [3:0]  req_sel;
    logic [3:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic [1:0]  alu_sel;
    logic [11:0] alu_y;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [11:0] rsp_y;

    logic [1:0]  lv;
    logic        lrdy;
    logic [1:0]  l0_ready, l15_ready;
    logic [3:0]  l0_a, l0_b, l15_a, l15_b;
    logic [2:0]  l0_op, l15_op;
    logic [1:0]  l0_sel, l15_sel;
    logic [11:0] l0_y, l15_y, l0_rsp_y, l15_rsp_y;
    logic        l0_rsp_valid, l15_rsp_valid, l0_rsp_id, l15_rsp_id;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] op_count, l0_op_count, l15_op_count;
    logic        busy, l0_busy, l15_busy;
`endif

    // Stand-in for the ALU: packs the operands so every field is visible in Y.
    function automatic logic [11:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                              input logic [2:0] op, input logic [1:0] sel);
        return {a, b, sel, op[1:0]} ^ {11'd0, op[2]};
    endfunction

    assign alu_y = alu_model(alu_a, alu_b, alu_op, alu_sel);
    assign l0_y  = alu_model(l0_a, l0_b, l0_op, l0_sel);
    assign l15_y = alu_model(l15_a, l15_b, l15_op, l15_sel);

    alu_op_arbiter #(.ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_sel(req_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sel(alu_sel), .alu_y(alu_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y)
`ifdef ALU_ARB_STATS_EN
        , .op_count(op_count), .busy(busy)
`endif
    );

    alu_op_arbiter #(.ALU_LAT(0)) dut_l0 (
        .clk(clk), .rst_n(rst_n), .req_valid(lv), .req_ready(l0_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_sel(req_sel),
        .alu_a(l0_a), .alu_b(l0_b), .alu_op(l0_op), .alu_sel(l0_sel), .alu_y(l0_y),
        .rsp_valid(l0_rsp_valid), .rsp_ready(lrdy), .rsp_id(l0_rsp_id), .rsp_y(l0_rsp_y)
`ifdef ALU_ARB_STATS_EN
        , .op_count(l0_op_count), .busy(l0_busy)
`endif
    );

    alu_op_arbiter #(.ALU_LAT(15)) dut_l15 (
        .clk(clk), .rst_n(rst_n), .req_valid(lv), .req_ready(l15_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_sel(req_sel),
        .alu_a(l15_a), .alu_b(l15_b), .alu_op(l15_op), .alu_sel(l15_sel), .alu_y(l15_y),
        .rsp_valid(l15_rsp_valid), .rsp_ready(lrdy), .rsp_id(l15_rsp_id), .rsp_y(l15_rsp_y)
`ifdef ALU_ARB_STATS_EN
        , .op_count(l15_op_count), .busy(l15_busy)
`endif
    );

    int total = 0;
    int bad   = 0;
    int n, n0, n15, hs_cnt;
    logic [11:0] held_y;
    logic        held_id;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges from the grant cycle until rsp_valid; bounded so a stuck DUT still reaches the summary.
    task automatic wait_rsp(output int cnt);
        cnt = 1;
        while (!rsp_valid && cnt < 40) begin
            step();
            cnt++;
        end
    endtask

    task automatic handshake();
        $display("txn: id=%0d y=%03h", rsp_id, rsp_y);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        hs_cnt++;
        chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        lv        = 2'b00;
        lrdy      = 1'b0;
        hs_cnt    = 0;
        // requester 1: A=0 B=F op=001 sel=10; requester 0: A=F B=F op=000 sel=01
        req_a     = {4'h0, 4'hF};
        req_b     = {4'hF, 4'hF};
        req_op    = {3'b001, 3'b000};
        req_sel   = {2'b10, 2'b01};
        step();
        step();

        // Reset state, with both requests held high during reset
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_alu_a", {28'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {28'd0, alu_b}, 32'd0);
        chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
        chk("rst_alu_sel", {30'd0, alu_sel}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_rsp_y", {20'd0, rsp_y}, 32'd0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        step();

        // Single request from requester 0
        req_valid = 2'b01;
        #1;
        chk("t1_grant", {30'd0, req_ready}, 32'h1);
        step();
        req_valid = 2'b00;
        #1;
        chk("t1_ready_off", {30'd0, req_ready}, 32'd0);
        chk("t1_alu_a", {28'd0, alu_a}, 32'hF);
        chk("t1_alu_b", {28'd0, alu_b}, 32'hF);
        chk("t1_alu_op", {29'd0, alu_op}, 32'h0);
        chk("t1_alu_sel", {30'd0, alu_sel}, 32'h1);
        wait_rsp(n);
        chk("t1_latency", n, 32'd3);
        chk("t1_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("t1_rsp_y", {20'd0, rsp_y}, 32'hFF4);
        step();
        chk("t1_hold_valid", {31'd0, rsp_valid}, 32'd1);
        handshake();
        chk("t1_alu_retain", {28'd0, alu_a}, 32'hF);

        // Contention at reset exit: requester 0 first
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        hs_cnt = 0;
        req_valid = 2'b11;
        #1;
        chk("t2_grant0", {30'd0, req_ready}, 32'h1);
        step();
        req_valid = 2'b10;
        #1;
        chk("t2_wait_noready", {30'd0, req_ready}, 32'd0);
        req_valid = 2'b11;
        wait_rsp(n);
        chk("t2_latency0", n, 32'd3);
        chk("t2_rsp_id0", {31'd0, rsp_id}, 32'd0);
        held_y  = rsp_y;
        held_id = rsp_id;
        // Backpressure for 10 cycles with both requesters waiting
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_rsp_y", {20'd0, rsp_y}, {20'd0, held_y});
            chk("bp_rsp_id", {31'd0, rsp_id}, {31'd0, held_id});
            chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
        end
        handshake();
        chk("t2_grant1", {30'd0, req_ready}, 32'h2);
        step();
        req_valid = 2'b01;
        #1;
        chk("t2_alu_a1", {28'd0, alu_a}, 32'h0);
        chk("t2_alu_b1", {28'd0, alu_b}, 32'hF);
        chk("t2_alu_op1", {29'd0, alu_op}, 32'h1);
        chk("t2_alu_sel1", {30'd0, alu_sel}, 32'h2);
        wait_rsp(n);
        chk("t2_latency1", n, 32'd3);
        chk("t2_rsp_id1", {31'd0, rsp_id}, 32'd1);
        chk("t2_rsp_y1", {20'd0, rsp_y}, 32'h0F9);
        handshake();
        chk("t2_alternate", {30'd0, req_ready}, 32'h1);
        step();
        req_valid = 2'b00;
        wait_rsp(n);
        chk("t2_rsp_id2", {31'd0, rsp_id}, 32'd0);
        handshake();

        // Async reset during WAIT discards the in-flight op
        req_valid = 2'b10;
        #1;
        chk("t3_grant1", {30'd0, req_ready}, 32'h2);
        step();
        req_valid = 2'b00;
        step();
        rst_n = 1'b0;
        #1;
        hs_cnt = 0;
        chk("t3_alu_a", {28'd0, alu_a}, 32'd0);
        chk("t3_alu_b", {28'd0, alu_b}, 32'd0);
        chk("t3_alu_op", {29'd0, alu_op}, 32'd0);
        chk("t3_alu_sel", {30'd0, alu_sel}, 32'd0);
        chk("t3_rsp_id", {31'd0, rsp_id}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        req_valid = 2'b11;
        #1;
        chk("t3_rr_reset", {30'd0, req_ready}, 32'h1);
        step();
        req_valid = 2'b00;
        wait_rsp(n);
        chk("t3_latency", n, 32'd3);
        chk("t3_rsp_y", {20'd0, rsp_y}, 32'hFF4);
        handshake();

        // Latency boundaries: ALU_LAT=0 and ALU_LAT=15, requester 0 A=3 B=5 op=110 sel=11
        req_a   = {4'h0, 4'h3};
        req_b   = {4'hF, 4'h5};
        req_op  = {3'b001, 3'b110};
        req_sel = {2'b10, 2'b11};
        lv = 2'b01;
        #1;
        chk("l0_grant", {30'd0, l0_ready}, 32'h1);
        chk("l15_grant", {30'd0, l15_ready}, 32'h1);
        step();
        lv = 2'b00;
        n0 = 0;
        n15 = 0;
        for (int c = 1; c <= 30; c++) begin
            if (n0 == 0 && l0_rsp_valid) n0 = c;
            if (n15 == 0 && l15_rsp_valid) n15 = c;
            step();
        end
        chk("l0_latency", n0, 32'd2);
        chk("l15_latency", n15, 32'd17);
        chk("l0_rsp_y", {20'd0, l0_rsp_y}, 32'h35F);
        chk("l15_rsp_y", {20'd0, l15_rsp_y}, 32'h35F);
        chk("l15_rsp_id", {31'd0, l15_rsp_id}, 32'd0);
        $display("txn: lat0 id=%0d y=%03h lat15 id=%0d y=%03h", l0_rsp_id, l0_rsp_y, l15_rsp_id, l15_rsp_y);
        lrdy = 1'b1;
        step();
        lrdy = 1'b0;
        chk("l0_drop", {31'd0, l0_rsp_valid}, 32'd0);
        chk("l15_drop", {31'd0, l15_rsp_valid}, 32'd0);

`ifdef ALU_ARB_STATS_EN
        chk("st_count_pre", {16'd0, op_count}, hs_cnt);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        hs_cnt = 0;
        chk("st_count_rst", {16'd0, op_count}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk("st_busy_idle", {31'd0, busy}, 32'd0);
            req_valid = 2'b11;
            step();
            req_valid = 2'b00;
            chk("st_busy_wait", {31'd0, busy}, 32'd1);
            wait_rsp(n);
            chk("st_busy_resp", {31'd0, busy}, 32'd1);
            handshake();
        end
        chk("st_busy_end", {31'd0, busy}, 32'd0);
        chk("st_count5", {16'd0, op_count}, 32'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
